regfile_bus_master: RTL
=======================

// Module: regfile_bus_master
// PURPOSE
//  Initiator for the 32-bit BRAM-style register-file port (addr/din/dout/en/rst/we) served by mem_regfile.
//  Converts a valid/ready request stream (read or byte-masked write) into single port accesses.
//  Returns one response per request, carrying read data for reads.
//  Lets fabric logic (sequencers, self-test) reach the register map without the processor.
// PARAMETERS
//  Naddr   4   word-address width; the port byte address is {req_addr,2'b00}, zero-extended to 12 bits
//  RdLat   1   responder read latency in clocks, from the en/addr sampling edge to valid regfile_dout (1..4)
// PORTS
//  axi_aclk      in   1      single clock; all logic on the rising edge
//  axi_aresetn   in   1      asynchronous, active-low reset
//  req_valid     in   1      request present
//  req_ready     out  1      request accepted when req_valid & req_ready
//  req_write     in   1      1 = write, 0 = read
//  req_addr      in   Naddr  word address
//  req_wdata     in   32     write data
//  req_wstrb     in   4      byte enables for writes (bit i -> byte i)
//  rsp_valid     out  1      response present
//  rsp_ready     in   1      response consumed when rsp_valid & rsp_ready
//  rsp_write     out  1      echo of req_write for this response
//  rsp_rdata     out  32     read data; 0 for writes
//  regfile_addr  out  12     byte address to the responder
//  regfile_din   out  32     write data to the responder
//  regfile_dout  in   32     read data from the responder
//  regfile_en    out  1      port enable, one-cycle pulse per access
//  regfile_we    out  4      byte write enables, valid only with regfile_en
//  regfile_rst   out  1      responder output reset; held 0
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE. req_ready=1. rsp_valid=0, rsp_write=0, rsp_rdata=0.
//   All regfile_* outputs = 0. Any in-flight access is dropped with no response.
//  All outputs are registered. No combinational path from any input to any output.
//  FSM states:
//   IDLE:  req_ready=1. On handshake at edge E0: capture write/addr/wdata/wstrb and drive the access.
//          Next state is ISSUE. req_ready=0 from E0 on.
//   ISSUE (one cycle, E0..E1):
//    - regfile_en=1 and regfile_addr={req_addr,2'b00}.
//    - regfile_we=wstrb for writes, 4'h0 for reads. regfile_din=wdata for writes, 0 for reads.
//    - Write with wstrb==0: regfile_en stays 0 (no access) but the write still completes normally.
//    - At E1: regfile_en and regfile_we return to 0. Writes go to RESP; reads go to WAIT.
//   WAIT:  count RdLat edges from E1. At edge E(1+RdLat): rsp_rdata<=regfile_dout, rsp_write<=0, go to RESP.
//   RESP:  rsp_valid=1 with stable rsp_write/rsp_rdata until the rsp handshake edge.
//          At that edge: rsp_valid=0, state IDLE, req_ready=1.
//  Latency (rsp_ready held 1):
//   - write: rsp_valid is high in the cycle after E1 (2 cycles after the handshake).
//   - read: rsp_valid is high after E(1+RdLat), i.e. RdLat+2 cycles after the handshake.
//  Throughput: one outstanding transaction. Next req handshake is possible one cycle after the rsp handshake.
//  Write response: rsp_write=1 and rsp_rdata=0.
//  req_* inputs are ignored outside IDLE; a request held across a busy period is taken when IDLE returns.
//  Address is fixed width; no wrap or range check. Unused upper regfile_addr bits are 0.
//  regfile_dout is sampled only on the capture edge; its value at any other time is don't-care.
//  Reset asserted mid-transaction: outputs go to reset values immediately, even within ISSUE.
//   The port access may be truncated; the engine restarts in IDLE.
// TESTING (bench: mem_regfile model, Naddr=4, RdLat=1 unless stated)
//  1 write addr=2 wdata=0x000000A5 wstrb=4'hF -> one en pulse, addr=0x008, we=4'hF, din=0x000000A5;
//    rsp_valid 2 cycles after handshake, rsp_write=1, rsp_rdata=0; model reg 2 == 0x000000A5.
//  2 read addr=0 (model returns 0xDEADBEEF) -> en=1, we=0 for one cycle, addr=0x000;
//    rsp_valid 3 cycles after handshake, rsp_rdata=0xDEADBEEF, rsp_write=0.
//  3 write addr=5 wdata=0x12345678 wstrb=4'b0011 over init 0x55555555, then read addr=5
//    -> rsp_rdata=0x55555678; a write with wstrb=0 -> no en pulse, rsp still returned.
//  4 back-to-back reads of addr 0..15, rsp_ready low 5 cycles on the 3rd -> rsp held stable, req_ready=0
//    throughout, no extra en pulses; 16 responses in order, each matching the model.
//  5 RdLat=3 build, read addr=1 (0x01234567) -> data captured 3 edges after E1, rsp_valid 5 cycles after handshake.
//  6 axi_aresetn low during WAIT of a read -> rsp_valid, regfile_en, regfile_we go 0 immediately;
//    after release req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/regfile_bus_master_if.sv
// Request/response stream and BRAM-style register-file port bundled as one interface.
// The master modport is the bus engine's view; slave is the view of whoever sits around it.
interface regfile_bus_master_if #(
  parameter int Naddr = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [Naddr-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_write;
  logic [31:0]      rsp_rdata;
  logic [11:0]      regfile_addr;
  logic [31:0]      regfile_din;
  logic [31:0]      regfile_dout;
  logic             regfile_en;
  logic [3:0]       regfile_we;
  logic             regfile_rst;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, regfile_dout,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
    output regfile_addr, regfile_din, regfile_en, regfile_we, regfile_rst
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, regfile_dout,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
    input  regfile_addr, regfile_din, regfile_en, regfile_we, regfile_rst
  );
endinterface

// File: rtl/regfile_bus_master.sv
// Turns a valid/ready request stream into single accesses on the register-file port,
// returning one response per request. One transaction in flight; every output is a flop.
module regfile_bus_master #(
  parameter int Naddr = 4,
  parameter int RdLat = 1
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  regfile_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [11:0] rf_addr_q, rf_addr_d;
  logic [31:0] rf_din_q, rf_din_d;
  logic        rf_en_q, rf_en_d;
  logic [3:0]  rf_we_q, rf_we_d;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rf_addr_q   <= '0;
      rf_din_q    <= '0;
      rf_en_q     <= 1'b0;
      rf_we_q     <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rf_addr_q   <= rf_addr_d;
      rf_din_q    <= rf_din_d;
      rf_en_q     <= rf_en_d;
      rf_we_q     <= rf_we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rf_addr_d   = rf_addr_q;
    rf_din_d    = rf_din_q;
    rf_en_d     = rf_en_q;
    rf_we_d     = rf_we_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d                = bus.req_write;
          rf_addr_d              = '0;
          rf_addr_d[Naddr+1:2]   = bus.req_addr;
          // A write with no byte enables completes without touching the port.
          rf_en_d                = !bus.req_write || (bus.req_wstrb != 4'h0);
          rf_we_d                = bus.req_write ? bus.req_wstrb : 4'h0;
          rf_din_d               = bus.req_write ? bus.req_wdata : 32'h0;
          req_ready_d            = 1'b0;
          state_d                = ISSUE;
        end
      end
      ISSUE: begin
        rf_en_d = 1'b0;
        rf_we_d = 4'h0;
        if (write_q) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = 32'h0;
          state_d     = RESP;
        end else begin
          cnt_d   = 2'(RdLat - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = bus.regfile_dout;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.regfile_addr = rf_addr_q;
  assign bus.regfile_din  = rf_din_q;
  assign bus.regfile_en   = rf_en_q;
  assign bus.regfile_we   = rf_we_q;
  assign bus.regfile_rst  = 1'b0;

endmodule
